// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs on the core's single-cycle bus.
// Registers: TXDATA, RXDATA, STATUS, DIVISOR in a 16-byte window.
module mmio_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] P1 = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_st_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK
  } rx_st_e;

  logic        sel, wr, rd;
  logic [1:0]  off;
  logic [31:0] wdata, rdata;
  logic        wr_tx, wr_rx, wr_st, wr_div;
  logic        unused_bits;

  logic [15:0] div_q, div_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        ferr_q, ferr_d;

  logic [7:0]  txm_q [FIFO_DEPTH];
  logic [AW:0] txw_q, txw_d, txr_q, txr_d;
  logic        tx_full, tx_fempty;
  logic        tx_push, tx_pop, tx_push_ok;
  logic [7:0]  tx_head;

  tx_st_e      txs_q, txs_d;
  logic [15:0] txc_q, txc_d;
  logic [2:0]  txb_q, txb_d;
  logic [7:0]  txsh_q, txsh_d;
  logic        tx_q, tx_d;
  logic        tx_busy, tx_empty;

  logic [2:0]  sync_q;
  logic        rx_s, rx_fall;
  rx_st_e      rxs_q, rxs_d;
  logic [15:0] rxc_q, rxc_d;
  logic [2:0]  rxb_q, rxb_d;
  logic [7:0]  rxsh_q, rxsh_d;
  logic        rx_push, rx_ferr;

  logic [7:0]  rxm_q [FIFO_DEPTH];
  logic [AW:0] rxw_q, rxw_d, rxr_q, rxr_d;
  logic        rx_full, rx_fempty;
  logic        rx_pop, rx_push_ok;
  logic [7:0]  rx_head;
  logic        rx_valid;
  logic [7:0]  status;

  assign wdata = mem_data;
  assign sel = (mem_size != 2'd0) &&
               (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign wr  = sel && mem_rw;
  assign rd  = sel && !mem_rw;
  assign off = mem_addr[3:2];

  assign wr_tx  = wr && (off == 2'd0);
  assign wr_rx  = wr && (off == 2'd1);
  assign wr_st  = wr && (off == 2'd2);
  assign wr_div = wr && (off == 2'd3);

  assign unused_bits = ^{mem_addr[1:0], wdata[31:16]};

  // TX FIFO
  assign tx_fempty = (txw_q == txr_q);
  assign tx_full   = (txw_q[AW] != txr_q[AW]) &&
                     (txw_q[AW-1:0] == txr_q[AW-1:0]);
  assign tx_head   = txm_q[txr_q[AW-1:0]];
  assign tx_push    = wr_tx;
  assign tx_push_ok = tx_push && (!tx_full || tx_pop);
  assign txw_d = tx_push_ok ? txw_q + P1 : txw_q;
  assign txr_d = tx_pop ? txr_q + P1 : txr_q;

  // RX FIFO
  assign rx_fempty = (rxw_q == rxr_q);
  assign rx_full   = (rxw_q[AW] != rxr_q[AW]) &&
                     (rxw_q[AW-1:0] == rxr_q[AW-1:0]);
  assign rx_head   = rx_fempty ? 8'h00 : rxm_q[rxr_q[AW-1:0]];
  assign rx_pop     = wr_rx && !rx_fempty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  assign rxw_d = rx_push_ok ? rxw_q + P1 : rxw_q;
  assign rxr_d = rx_pop ? rxr_q + P1 : rxr_q;

  assign div_d = wr_div ? wdata[15:0] : div_q;

  // Set wins over a same-cycle write-1-to-clear
  assign tx_ovf_d = (tx_ovf_q & ~(wr_st & wdata[5])) |
                    (tx_push & ~tx_push_ok);
  assign rx_ovf_d = (rx_ovf_q & ~(wr_st & wdata[6])) |
                    (rx_push & ~rx_push_ok);
  assign ferr_d   = (ferr_q & ~(wr_st & wdata[7])) | rx_ferr;

  assign tx_busy  = (txs_q != TX_IDLE);
  assign tx_empty = tx_fempty && !tx_busy;
  assign rx_valid = !rx_fempty;
  assign status   = {ferr_q, rx_ovf_q, tx_ovf_q, tx_busy,
                     rx_full, rx_valid, tx_empty, tx_full};

  always_comb begin
    rdata = '0;
    unique case (off)
      2'd0: rdata = '0;
      2'd1: rdata = {24'b0, rx_head};
      2'd2: rdata = {24'b0, status};
      2'd3: rdata = {16'b0, div_q};
    endcase
  end

  assign mem_data = rd ? rdata : 32'bz;
  assign uart_tx  = tx_q;
  assign irq      = rx_valid | tx_ovf_q | rx_ovf_q | ferr_q;

  always_comb begin
    txs_d  = txs_q;
    txc_d  = txc_q;
    txb_d  = txb_q;
    txsh_d = txsh_q;
    tx_pop = 1'b0;
    unique case (txs_q)
      TX_IDLE: begin
        if (!tx_fempty) begin
          tx_pop = 1'b1;
          txsh_d = tx_head;
          txc_d  = div_q;
          txs_d  = TX_START;
        end
      end
      TX_START: begin
        if (txc_q == 16'd0) begin
          txc_d = div_q;
          txb_d = 3'd0;
          txs_d = TX_DATA;
        end else begin
          txc_d = txc_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (txc_q == 16'd0) begin
          txc_d  = div_q;
          txsh_d = {1'b0, txsh_q[7:1]};
          if (txb_q == 3'd7) txs_d = TX_STOP;
          else txb_d = txb_q + 3'd1;
        end else begin
          txc_d = txc_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (txc_q == 16'd0) begin
          // Chain straight into the next start bit
          if (!tx_fempty) begin
            tx_pop = 1'b1;
            txsh_d = tx_head;
            txc_d  = div_q;
            txs_d  = TX_START;
          end else begin
            txs_d = TX_IDLE;
          end
        end else begin
          txc_d = txc_q - 16'd1;
        end
      end
    endcase
    tx_d = 1'b1;
    if (txs_d == TX_START) tx_d = 1'b0;
    else if (txs_d == TX_DATA) tx_d = txsh_d[0];
  end

  assign rx_s    = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];

  always_comb begin
    rxs_d   = rxs_q;
    rxc_d   = rxc_q;
    rxb_d   = rxb_q;
    rxsh_d  = rxsh_q;
    rx_push = 1'b0;
    rx_ferr = 1'b0;
    case (rxs_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rxc_d = div_q >> 1;
          rxs_d = RX_START;
        end
      end
      RX_START: begin
        if (rxc_q == 16'd0) begin
          if (rx_s) begin
            rxs_d = RX_IDLE;
          end else begin
            rxc_d = div_q;
            rxb_d = 3'd0;
            rxs_d = RX_DATA;
          end
        end else begin
          rxc_d = rxc_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rxc_q == 16'd0) begin
          rxsh_d = {rx_s, rxsh_q[7:1]};
          rxc_d  = div_q;
          if (rxb_q == 3'd7) rxs_d = RX_STOP;
          else rxb_d = rxb_q + 3'd1;
        end else begin
          rxc_d = rxc_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rxc_q == 16'd0) begin
          if (rx_s) begin
            rx_push = 1'b1;
            rxs_d   = RX_IDLE;
          end else begin
            rx_ferr = 1'b1;
            rxs_d   = RX_BRK;
          end
        end else begin
          rxc_d = rxc_q - 16'd1;
        end
      end
      RX_BRK: begin
        if (rx_s) rxs_d = RX_IDLE;
      end
      default: rxs_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q    <= DIV_RESET;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      ferr_q   <= 1'b0;
      txw_q    <= '0;
      txr_q    <= '0;
      rxw_q    <= '0;
      rxr_q    <= '0;
      txs_q    <= TX_IDLE;
      txc_q    <= '0;
      txb_q    <= '0;
      txsh_q   <= '0;
      tx_q     <= 1'b1;
      sync_q   <= 3'b111;
      rxs_q    <= RX_IDLE;
      rxc_q    <= '0;
      rxb_q    <= '0;
      rxsh_q   <= '0;
    end else begin
      div_q    <= div_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      ferr_q   <= ferr_d;
      txw_q    <= txw_d;
      txr_q    <= txr_d;
      rxw_q    <= rxw_d;
      rxr_q    <= rxr_d;
      txs_q    <= txs_d;
      txc_q    <= txc_d;
      txb_q    <= txb_d;
      txsh_q   <= txsh_d;
      tx_q     <= tx_d;
      sync_q   <= {sync_q[1:0], uart_rx};
      rxs_q    <= rxs_d;
      rxc_q    <= rxc_d;
      rxb_q    <= rxb_d;
      rxsh_q   <= rxsh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) txm_q[txw_q[AW-1:0]] <= wdata[7:0];
    if (rx_push_ok) rxm_q[rxw_q[AW-1:0]] <= rxsh_q;
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: bus access, TX framing,
// loopback RX, error flags and address decode.
module tb_mmio_uart;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wval = '0;
  logic        rw = 1'b0;
  logic        wen = 1'b0;
  logic [1:0]  size = 2'd0;
  tri1  [31:0] mem_data;
  logic        uart_tx, uart_rx, irq;
  logic        loop = 1'b0;
  logic        rx_drv = 1'b1;
  logic        mon_en = 1'b1;

  int          checks = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_rx[$];
  int unsigned st_q[$];
  logic [7:0]  mon_b;

  assign mem_data = wen ? wval : 32'bz;
  assign uart_rx  = loop ? uart_tx : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_uart #(
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(8),
    .DIV_RESET(16'd867)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(addr),
    .mem_data(mem_data),
    .mem_rw(rw),
    .mem_size(size),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx),
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] v,
                        input logic [1:0] sz);
    @(negedge clk);
    addr = a; wval = v; wen = 1'b1; rw = 1'b1; size = sz;
    @(posedge clk);
    #1;
    wen = 1'b0; rw = 1'b0; size = 2'd0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d,
                      input logic [1:0] sz);
    addr = a; rw = 1'b0; size = sz;
    #1;
    d = mem_data;
    size = 2'd0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    peek(a, d, 2'd3);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    int n;
    n = 0;
    rd_reg(BASE + 32'h8, d);
    while (d[4] && n < 400) begin
      rd_reg(BASE + 32'h8, d);
      n++;
    end
    chk(tag, {63'b0, d[4]}, 64'd0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = fr[i];
      repeat (3) @(negedge clk);
    end
  endtask

  // Serial monitor for uart_tx at 4 clocks per bit
  always begin
    @(negedge clk);
    if (mon_en && rst && uart_tx === 1'b0) begin
      st_q.push_back(cyc);
      repeat (6) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        mon_b[j] = uart_tx;
        if (j < 7) repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("tx_stop_bit", {63'b0, uart_tx}, 64'd1);
      chk("tx_sb_nonempty", {63'b0, exp_tx.size() != 0}, 64'd1);
      if (exp_tx.size() != 0)
        chk("tx_frame_data", {56'b0, mon_b}, {56'b0, exp_tx.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [39:0] wave, wexp;
    logic [9:0]  fr;
    int n;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_uart_tx", {63'b0, uart_tx}, 64'd1);
    chk("rst_irq", {63'b0, irq}, 64'd0);
    rd_reg(BASE + 32'h8, d);
    chk("rst_status", {32'b0, d}, 64'h02);
    rd_reg(BASE + 32'hC, d);
    chk("rst_divisor", {32'b0, d}, 64'h363);

    wr_reg(BASE + 32'hC, 32'd3, 2'd3);
    rd_reg(BASE + 32'hC, d);
    chk("divisor_wr", {32'b0, d}, 64'd3);

    // Single 0x55 frame with exact waveform and busy timing
    exp_tx.push_back(8'h55);
    wr_reg(BASE, 32'h55, 2'd3);
    n = 0;
    while (uart_tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", {63'b0, n < 50}, 64'd1);
    wave = '0;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 40) wave[i] = uart_tx;
      peek(BASE + 32'h8, d, 2'd3);
      if (i == 39) chk("tx_busy_39", {63'b0, d[4]}, 64'd1);
      if (i == 40) chk("status_after_tx", {32'b0, d}, 64'h02);
    end
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) wexp[i] = fr[i/4];
    chk("tx_wave_55", {24'b0, wave}, {24'b0, wexp});

    // Overflow burst of 10 writes
    st_q.delete();
    for (int k = 0; k < 10; k++) begin
      if (k < 9) exp_tx.push_back(8'(8'h10 + k));
      wr_reg(BASE, 32'(32'h10 + k), 2'd3);
    end
    rd_reg(BASE + 32'h8, d);
    chk("ovf_status", {32'b0, d}, 64'h31);
    chk("ovf_irq", {63'b0, irq}, 64'd1);
    wr_reg(BASE + 32'h8, 32'h20, 2'd3);
    rd_reg(BASE + 32'h8, d);
    chk("ovf_cleared", {32'b0, d}, 64'h11);
    chk("ovf_irq_clr", {63'b0, irq}, 64'd0);
    n = 0;
    while (exp_tx.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("tx_drain", 64'(exp_tx.size()), 64'd0);
    chk("tx_frames", 64'(st_q.size()), 64'd9);
    if (st_q.size() == 9)
      chk("tx_contig", 64'(st_q[8] - st_q[0]), 64'd320);
    wait_idle("burst_idle");

    // Loopback
    @(negedge clk);
    loop = 1'b1;
    exp_tx.push_back(8'hA3);
    exp_rx.push_back(8'hA3);
    wr_reg(BASE, 32'hA3, 2'd3);
    n = 0;
    rd_reg(BASE + 32'h8, d);
    while (!d[2] && n < 200) begin
      rd_reg(BASE + 32'h8, d);
      n++;
    end
    chk("lb_rx_valid", {63'b0, d[2]}, 64'd1);
    chk("lb_irq", {63'b0, irq}, 64'd1);
    rd_reg(BASE + 32'h4, d);
    chk("lb_rxdata_1", {32'b0, d}, {56'b0, exp_rx[0]});
    rd_reg(BASE + 32'h4, d);
    chk("lb_rxdata_2", {32'b0, d}, {56'b0, exp_rx.pop_front()});
    wr_reg(BASE + 32'h4, 32'h0, 2'd3);
    wait_idle("lb_idle");
    rd_reg(BASE + 32'h8, d);
    chk("lb_popped", {32'b0, d}, 64'h02);
    chk("lb_irq_low", {63'b0, irq}, 64'd0);
    loop = 1'b0;

    // Externally driven good frame
    exp_rx.push_back(8'hC4);
    send_rx(8'hC4, 1'b1);
    repeat (6) @(posedge clk);
    rd_reg(BASE + 32'h8, d);
    chk("rx_status", {32'b0, d}, 64'h06);
    rd_reg(BASE + 32'h4, d);
    chk("rx_data", {32'b0, d}, {56'b0, exp_rx.pop_front()});
    wr_reg(BASE + 32'h4, 32'h0, 2'd3);

    // One-clock glitch must not start a frame
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(posedge clk);
    rd_reg(BASE + 32'h8, d);
    chk("false_start", {32'b0, d}, 64'h02);

    // Stop bit 0, then break held low
    send_rx(8'h5A, 1'b0);
    repeat (8) @(negedge clk);
    rx_drv = 1'b1;
    repeat (10) @(posedge clk);
    rd_reg(BASE + 32'h8, d);
    chk("frame_err", {32'b0, d}, 64'h82);
    chk("frame_err_irq", {63'b0, irq}, 64'd1);
    rd_reg(BASE + 32'h4, d);
    chk("frame_err_rxdata", {32'b0, d}, 64'd0);
    wr_reg(BASE + 32'h8, 32'h80, 2'd3);
    rd_reg(BASE + 32'h8, d);
    chk("frame_err_clr", {32'b0, d}, 64'h02);

    // Address decode
    @(negedge clk);
    peek(BASE + 32'h10, d, 2'd3);
    chk("unsel_addr_z", {32'b0, d}, 64'hFFFFFFFF);
    @(negedge clk);
    peek(BASE + 32'hC, d, 2'd0);
    chk("size0_z", {32'b0, d}, 64'hFFFFFFFF);
    rd_reg(BASE, d);
    chk("txdata_reads_0", {32'b0, d}, 64'd0);
    wr_reg(BASE + 32'h10, 32'h77, 2'd3);
    wr_reg(BASE, 32'h77, 2'd0);
    wr_reg(BASE + 32'hC, 32'h9, 2'd0);
    rd_reg(BASE + 32'h8, d);
    chk("no_side_effect", {32'b0, d}, 64'h02);
    rd_reg(BASE + 32'hC, d);
    chk("div_unchanged", {32'b0, d}, 64'd3);
    exp_tx.push_back(8'h3C);
    wr_reg(BASE + 32'h1, 32'h3C, 2'd1);
    rd_reg(BASE + 32'h8, d);
    chk("byte_wr_queued", {32'b0, d}, 64'h00);
    n = 0;
    while (exp_tx.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("byte_wr_sent", 64'(exp_tx.size()), 64'd0);
    wait_idle("byte_idle");

    // Reset in the middle of a frame
    mon_en = 1'b0;
    wr_reg(BASE, 32'h81, 2'd3);
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx_high", {63'b0, uart_tx}, 64'd1);
    rst = 1'b1;
    rd_reg(BASE + 32'h8, d);
    chk("abort_status", {32'b0, d}, 64'h02);
    rd_reg(BASE + 32'hC, d);
    chk("abort_divisor", {32'b0, d}, 64'h363);

    chk("rx_sb_empty", 64'(exp_rx.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
